dmem_sram_port_ctrl: RTL and testbench

//  Request/response front end for the 32x512 data SRAM macro (port 0, RW), sitting between the core's load/store unit and the macro.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_clear_seq.sv | 37 +++
 rtl/dmem_sram_port_ctrl.sv | 144 ++++++++++++++
 tb/tb_dmem_sram_port_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_pkg : shared constants and FSM state type for the data SRAM port
// Rev 1.0
// ----------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR  = 32'h0000_1000;
  localparam int          DMEM_ADDR_WIDTH = 9;
  localparam int          DMEM_DEPTH      = 1 << DMEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2
  } dmem_state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_clear_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_clear_seq : word counter for the post-reset zero-fill sweep
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_clear_seq
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  // Counter wraps to zero after the last word, ready for the next sweep.
  assign cnt_d  = en_i ? (cnt_q + 1'b1) : cnt_q;
  assign addr_o = cnt_q;
  assign done_o = en_i && (cnt_q == LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : dmem_clear_seq
`default_nettype wire

// File: rtl/dmem_sram_port_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_sram_port_ctrl : valid/ready front end for the 32-bit data SRAM macro
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_sram_port_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DMEM_BASE_ADDR,
  parameter int          ADDR_WIDTH     = DMEM_ADDR_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [3:0]            req_be,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  busy_clear,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [3:0]            sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_din,
  input  logic [31:0]           sram_dout
);

  localparam logic [31:0]  SPAN_BYTES  = 32'd4 << ADDR_WIDTH;
  localparam dmem_state_e  RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  dmem_state_e           state_q;
  dmem_state_e           state_d;

  logic                  resp_valid_q;
  logic                  resp_we_q;
  logic                  resp_err_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;

  logic [31:0]           w_offset;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic                  w_stall;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_clr_en;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_clr_done;

  // Offset is unsigned 32-bit; addresses below BASE_ADDR are rejected by the
  // explicit lower-bound compare rather than relying on wrap-around.
  assign w_offset   = req_addr - BASE_ADDR;
  assign w_in_range = (req_addr >= BASE_ADDR) && (w_offset < SPAN_BYTES);
  assign w_word_idx = w_offset[ADDR_WIDTH+1:2];

  assign w_stall    = resp_valid_q && !resp_ready;
  assign w_ready    = !rst && (state_q != CLEAR) && !w_stall;
  assign w_accept   = req_valid && w_ready;
  assign w_clr_en   = !rst && (state_q == CLEAR);

  assign req_ready  = w_ready;
  assign busy_clear = (state_q == CLEAR);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_valid_q && resp_err_q;
  assign resp_rdata = (resp_valid_q && !resp_we_q && !resp_err_q) ? sram_dout : 32'd0;

  dmem_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk    (clk),
    .rst    (rst),
    .en_i   (w_clr_en),
    .addr_o (w_clr_addr),
    .done_o (w_clr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = 4'h0;
    sram_addr  = '0;
    sram_din   = 32'd0;
    if (!rst) begin
      unique case (state_q)
        CLEAR: begin
          sram_csb   = 1'b0;
          sram_web   = 1'b0;
          sram_wmask = 4'hF;
          sram_addr  = w_clr_addr;
          if (w_clr_done) begin
            state_d = RUN;
          end
        end
        RUN, HOLD: begin
          if (w_accept && w_in_range) begin
            sram_csb   = 1'b0;
            sram_web   = !req_we;
            sram_wmask = req_we ? req_be : 4'h0;
            sram_addr  = w_word_idx;
            sram_din   = req_wdata;
          end else if (w_stall && !resp_we_q && !resp_err_q) begin
            // Keep re-reading the held word so dout stays valid for the consumer.
            sram_csb  = 1'b0;
            sram_addr = resp_addr_q;
          end
          state_d = w_stall ? HOLD : RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_addr_q  <= '0;
    end else if (w_accept) begin
      resp_valid_q <= 1'b1;
      resp_we_q    <= req_we;
      resp_err_q   <= !w_in_range;
      resp_addr_q  <= w_in_range ? w_word_idx : '0;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

endmodule : dmem_sram_port_ctrl
`default_nettype wire

// File: tb/tb_dmem_sram_port_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_sram_port_ctrl : random + directed bench with SRAM macro model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dmem_sram_port_ctrl;

  localparam int DEPTH = 512;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy_clear;
  logic        sram_csb;
  logic        sram_web;
  logic [3:0]  sram_wmask;
  logic [8:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  dmem_sram_port_ctrl #(
    .BASE_ADDR      (32'h0000_1000),
    .ADDR_WIDTH     (9),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy_clear (busy_clear),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: pins sampled at posedge, write/read performed at the negedge.
  logic [31:0] sram_mem [DEPTH];
  logic        s_csb = 1'b1;
  logic        s_web = 1'b1;
  logic [3:0]  s_wm;
  logic [8:0]  s_a;
  logic [31:0] s_din;
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    s_csb <= sram_csb;
    s_web <= sram_web;
    s_wm  <= sram_wmask;
    s_a   <= sram_addr;
    s_din <= sram_din;
  end

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] = $urandom;
      mem_init = 1'b1;
    end
    if (!s_csb) begin
      if (!s_web) begin
        for (int b = 0; b < 4; b++)
          if (s_wm[b]) sram_mem[s_a][8*b +: 8] = s_din[8*b +: 8];
      end else begin
        sram_dout <= sram_mem[s_a];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: word array plus an in-order queue of expected responses.
  typedef struct {
    logic        err;
    logic        ld;
    logic [8:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic [31:0] model_mem [DEPTH];
  exp_t        expq [$];
  int          clr_left  = DEPTH;
  int          resp_cnt  = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  exp_t        m_e;
  exp_t        m_new;
  logic        m_pend;
  logic        m_rdy;
  logic        m_acc;
  logic        m_inr;
  logic [31:0] m_idx;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      clr_left = DEPTH;
      expq.delete();
    end else if (clr_left > 0) begin
      check("clr_busy",  busy_clear, 1);
      check("clr_ready", req_ready, 0);
      check("clr_rvalid", resp_valid, 0);
      check("clr_csb",   sram_csb, 0);
      check("clr_web",   sram_web, 0);
      check("clr_wmask", sram_wmask, 4'hF);
      check("clr_addr",  sram_addr, DEPTH - clr_left);
      check("clr_din",   sram_din, 0);
      model_mem[DEPTH - clr_left] = 32'd0;
      clr_left--;
    end else begin
      m_pend = expq.size() > 0;
      if (m_pend) m_e = expq[0];
      check("busy", busy_clear, 0);
      check("resp_valid", resp_valid, m_pend);
      if (m_pend) begin
        check("resp_rdata", resp_rdata, (m_e.ld && !m_e.err) ? m_e.data : 32'd0);
        check("resp_err", resp_err, m_e.err);
      end else begin
        check("idle_rdata", resp_rdata, 0);
      end
      m_rdy = !(m_pend && !resp_ready);
      check("req_ready", req_ready, m_rdy);
      m_acc = req_valid && m_rdy;
      m_inr = (req_addr >= 32'h1000) && (req_addr < 32'h1000 + 4 * DEPTH);
      m_idx = (req_addr - 32'h1000) / 4;
      if (m_acc && m_inr) begin
        check("acc_csb",   sram_csb, 0);
        check("acc_web",   sram_web, !req_we);
        check("acc_wmask", sram_wmask, req_we ? req_be : 4'h0);
        check("acc_addr",  sram_addr, m_idx);
        check("acc_din",   sram_din, req_wdata);
      end else if (m_pend && !resp_ready && m_e.ld && !m_e.err) begin
        check("hold_csb",  sram_csb, 0);
        check("hold_web",  sram_web, 1);
        check("hold_addr", sram_addr, m_e.idx);
      end else begin
        check("idle_csb",   sram_csb, 1);
        check("idle_web",   sram_web, 1);
        check("idle_wmask", sram_wmask, 0);
        check("idle_addr",  sram_addr, 0);
      end
      if (m_pend && resp_ready) begin
        last_rdata = resp_rdata;
        last_err   = resp_err;
        resp_cnt++;
        void'(expq.pop_front());
      end
      if (m_acc) begin
        m_new.err  = !m_inr;
        m_new.ld   = !req_we;
        m_new.idx  = m_inr ? m_idx[8:0] : 9'd0;
        m_new.data = m_inr ? model_mem[m_idx[8:0]] : 32'd0;
        if (m_inr && req_we)
          for (int b = 0; b < 4; b++)
            if (req_be[b]) model_mem[m_idx[8:0]][8*b +: 8] = req_wdata[8*b +: 8];
        expq.push_back(m_new);
      end
    end
  end

  // Drive one request from posedge+1 and return at posedge+1 after acceptance.
  task automatic send(input logic we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    int   n;
    logic ok;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
    do begin
      @(negedge clk); #2;
      ok = req_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    check("send_accepted", ok, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_cnt < target && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_arrived", resp_cnt >= target, 1);
  endtask

  task automatic wait_clear_done(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk); #2;
      if (!busy_clear || cycles > 600) break;
      cycles++;
    end
    @(posedge clk); #1;
  endtask

  int n_busy;
  int c0;
  int n_wait;
  int sel;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy_clear, 1);
    check("rst_csb", sram_csb, 1);
    check("rst_web", sram_web, 1);
    check("rst_wmask", sram_wmask, 0);
    rst = 1'b0;

    wait_clear_done(n_busy);
    check("clear_cycles", n_busy, DEPTH);

    c0 = resp_cnt;
    send(1'b0, 32'h1000, 4'h0, 32'h0);
    wait_resp(c0 + 1);
    check("cleared_word0", last_rdata, 32'h0);

    c0 = resp_cnt;
    send(1'b1, 32'h1004, 4'hF, 32'hDEAD_BEEF);
    send(1'b0, 32'h1004, 4'h0, 32'h0);
    wait_resp(c0 + 2);
    check("st_ld_fwd", last_rdata, 32'hDEAD_BEEF);

    c0 = resp_cnt;
    send(1'b1, 32'h1008, 4'b0101, 32'h1122_3344);
    send(1'b0, 32'h100A, 4'h0, 32'h0);
    wait_resp(c0 + 2);
    check("partial_be", last_rdata, 32'h0022_0044);

    c0 = resp_cnt;
    send(1'b0, 32'h1004, 4'h0, 32'h0);
    resp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #2;
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, 32'hDEAD_BEEF);
      check("hold_ready", req_ready, 0);
      check("hold_csb_d", sram_csb, 0);
      check("hold_web_d", sram_web, 1);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    wait_resp(c0 + 1);
    check("hold_final", last_rdata, 32'hDEAD_BEEF);

    c0 = resp_cnt;
    send(1'b0, 32'h0FFC, 4'h0, 32'h0);
    wait_resp(c0 + 1);
    check("below_err", last_err, 1);
    check("below_rdata", last_rdata, 0);
    c0 = resp_cnt;
    send(1'b0, 32'h1800, 4'h0, 32'h0);
    wait_resp(c0 + 1);
    check("above_err", last_err, 1);
    check("above_rdata", last_rdata, 0);
    c0 = resp_cnt;
    send(1'b0, 32'h17FC, 4'h0, 32'h0);
    wait_resp(c0 + 1);
    check("top_word_err", last_err, 0);

    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom % 3) != 0;
      req_we    = 1'($urandom % 2);
      sel       = int'($urandom % 10);
      if (sel == 0)      req_addr = $urandom;
      else if (sel == 1) req_addr = (($urandom % 2) != 0) ? 32'h0FFC : 32'h1800;
      else if (sel < 6)  req_addr = 32'h1000 + 4 * ($urandom % 16) + ($urandom % 4);
      else               req_addr = 32'h1000 + ($urandom % 2048);
      req_be     = 4'($urandom);
      req_wdata  = $urandom;
      resp_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    rst = 1'b1;
    @(negedge clk); #2;
    @(posedge clk); #1;
    rst = 1'b0;
    n_wait = 0;
    forever begin
      @(negedge clk); #2;
      if ((busy_clear && sram_addr == 9'd200) || n_wait > 600) break;
      n_wait++;
    end
    check("reached_word200", sram_addr, 200);
    rst = 1'b1;
    #1;
    check("async_rst_csb", sram_csb, 1);
    check("async_rst_ready", req_ready, 0);
    @(negedge clk); #2;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #2;
    check("restart_addr", sram_addr, 0);
    check("restart_csb", sram_csb, 0);
    check("restart_busy", busy_clear, 1);
    @(posedge clk); #1;
    wait_clear_done(n_busy);
    check("reclear_cycles", n_busy, DEPTH - 1);
    c0 = resp_cnt;
    send(1'b0, 32'h1004, 4'h0, 32'h0);
    wait_resp(c0 + 1);
    check("reclear_word1", last_rdata, 32'h0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_sram_port_ctrl
`default_nettype wire
